// File: rtl/pipo_rr_arbiter_if.sv
// Requester/consumer bus of the round-robin PIPO arbiter.
//   req      : per-requester request, bit i = requester i
//   pi       : requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt      : one-hot (or zero) combinational grant
//   po       : registered data word
//   po_valid : po holds an unconsumed word
//   po_src   : index of the requester that wrote po
//   po_ready : consumer accepts po this cycle
// master = requesters + consumer side, slave = arbiter side.
interface pipo_rr_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] pi;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   po;
  logic               po_valid;
  logic [SW-1:0]      po_src;
  logic               po_ready;

  modport master (
    output req, pi, po_ready,
    input  gnt, po, po_valid, po_src
  );

  modport slave (
    input  req, pi, po_ready,
    output gnt, po, po_valid, po_src
  );
endinterface

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit holding register among N
// requesters; the register feeds a single consumer via valid/ready.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear (drops valid, resets rotate pointer)
//   bus   : pipo_rr_arbiter_if.slave (req/pi/gnt, po/po_valid/po_src/po_ready)
module pipo_rr_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  pipo_rr_arbiter_if.slave   bus
);

  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  // Holding-register occupancy is the FSM state.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic [SW-1:0]    src_q, src_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             free;
  logic             found;
  logic [SW-1:0]    sel;
  int unsigned      idx;
  logic [N-1:0]     gnt_c;

  // Grant selection: first requester at or after ptr, wrapping at N.
  // Gated by rst_n so no grant is reported while reset is asserted.
  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    free  = (state_q == ST_EMPTY) || bus.po_ready;
    if (rst_n && free && !clr) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr_q) + k) % N;
        if (!found && bus.req[SW'(idx)]) begin
          found = 1'b1;
          sel   = SW'(idx);
        end
      end
    end
    if (found) gnt_c[sel] = 1'b1;
  end

  // Next-state: clr beats grant beats consume; otherwise hold.
  always_comb begin
    state_d = state_q;
    po_d    = po_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = ST_EMPTY;
      ptr_d   = '0;
    end else if (found) begin
      state_d = ST_FULL;
      po_d    = bus.pi[32'(sel)*WIDTH +: WIDTH];
      src_d   = sel;
      ptr_d   = (32'(sel) == N - 1) ? '0 : sel + SW'(1);
    end else if (state_q == ST_FULL && bus.po_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      po_q    <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      po_q    <= po_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.po       = po_q;
  assign bus.po_valid = (state_q == ST_FULL);
  assign bus.po_src   = src_q;

endmodule

// File: doc/pipo_rr_arbiter.md
# pipo_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register among N requesters. Each requester presents a word plus a request; the arbiter grants one per cycle and captures the granted word into the register. The register drives a single consumer through a valid/ready handshake, together with the index of the requester that wrote it. The block sits in front of the PIPO datapath stage and replaces ad-hoc sharing of that register.

## Interface
- WIDTH, 4, data word width in bits (1..32)
- N, 4, number of requesters (2..16); SW = $clog2(N) is the derived source-index width
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Clr  input  1  synchronous clear; highest priority after reset
- Req  input  N  per-requester request; bit i belongs to requester i
- Pi  input  N*WIDTH  requester data; requester i at bits [i*WIDTH +: WIDTH]
- Gnt  output  N  one-hot (or zero) grant, combinational
- Po  output  WIDTH  registered data word
- Po_valid  output  1  Po holds an unconsumed word
- Po_src  output  SW  index of the requester that wrote Po
- Po_ready  input  1  consumer accepts Po this cycle

## Operation
- Reset (Rst_n=0, async): Po=0, Po_valid=0, Po_src=0, rotate pointer ptr=0. Gnt=0 while Rst_n=0.
- Two-state FSM encoded by Po_valid: EMPTY (0), FULL (1).
- free = !Po_valid | Po_ready. Ready passes through combinationally, so a word can be replaced in the cycle it is consumed.
- Gnt selection: when free && !Clr && |Req, select the first i with Req[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. Gnt[i]=1 and all other bits are 0. Otherwise Gnt=0.
- On the clock edge with Gnt[i]=1:
  - Po <= Pi slice i; Po_src <= i; Po_valid <= 1.
  - ptr <= i+1, wrapping from N-1 to 0.
- No grant, Po_valid=1, Po_ready=1: Po_valid <= 0. Po and Po_src hold their last values.
- No grant, Po_valid=1, Po_ready=0: all registers hold (FULL stalls).
- ptr changes only on a grant.
- Clr=1: Po_valid <= 0 and ptr <= 0; Po and Po_src hold; Gnt forced to 0. Clr overrides any simultaneous grant or consume.
- Requester rule: a transfer occurs exactly on an edge where Req[i]&Gnt[i]=1. A requester keeps Req and its Pi slice stable until that edge. Dropping Req before a grant is legal, and nothing is captured.
- Consumer rule: a word is consumed exactly on an edge where Po_valid&Po_ready=1. Po and Po_src are stable while Po_valid=1 and Po_ready=0.
- Fairness: with all N requesters asserted continuously and Po_ready=1, grants are issued in the order ptr, ptr+1, … and each requester is granted once every N cycles.

## Timing
- Gnt has zero latency: it is a combinational function of Req, ptr, Po_valid, Po_ready and Clr.
- Captured data appears on Po/Po_valid one cycle after the grant edge.
- Throughput is one word per cycle while Po_ready=1 and any Req is high.
- Po_ready low blocks all grants in the same cycle whenever Po_valid=1.
- Reset deassertion: the first grant is possible on the first rising edge after Rst_n goes high.
- Reset asserted mid-transfer: the word is discarded and the block returns to the reset state immediately; no grant is reported for that cycle.

## Test plan
- Reset: hold Rst_n=0 with Req=4'b1111 -> Gnt=0, Po=0, Po_valid=0, Po_src=0. Release -> Gnt=4'b0001 on the first cycle.
- Round-robin: Req=4'b1111 for 8 cycles, Pi = {4'hD,4'hC,4'hB,4'hA}, Po_ready=1 -> Po_src sequence 0,1,2,3,0,1,2,3 and Po sequence A,B,C,D,A,B,C,D, one per cycle.
- Skip and wrap: ptr=3, Req=4'b0101 -> Gnt=4'b0001 and Po_src=0 next cycle; then ptr=1, so the next grant is 4'b0100.
- Backpressure: Po_valid=1, Po_ready=0 for 5 cycles with Req=4'b0010 -> Gnt=0, Po unchanged. Raise Po_ready -> Gnt=4'b0010 in that same cycle and the new word appears next cycle.
- Drain: a single word loaded, then Req=0 and Po_ready=1 -> Po_valid falls after one cycle while Po retains its value.
- Clr with a pending grant: Req=4'b1000 and Clr=1 in the same cycle -> Gnt=0, Po_valid=0, ptr=0. The next cycle, with Clr=0, grants 4'b1000.
